pulse_train_generator: RTL and testbench

Programmable pulse-train transmitter that drives up to NUM_OUTPUTS digital lines with a burst of rising edges of configurable high time, low time and count. It is the stimulus counterpart to the posedge counter: the counter measures edges on DUT lines, and this block produces them, for example for DUT clock/strobe injection or counter self-test by loopback. Configuration and status connect to a separate AXI4-Lite register wrapper, pulse_train_generator_interface, which is not part of this block.

---
 rtl/pulse_train_pkg.sv | 22 ++
 rtl/pulse_train_generator.sv | 94 +++++++++
 tb/tb_pulse_train_generator.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types for the pulse-train generator: FSM states, default widths and latched burst config.
package pulse_train_pkg;

  localparam int DEFAULT_CNT_WIDTH   = 32;
  localparam int DEFAULT_NUM_OUTPUTS = 8;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Burst configuration captured on start; held at the package widths.
  typedef struct packed {
    logic [DEFAULT_NUM_OUTPUTS-1:0] mask;
    logic [DEFAULT_CNT_WIDTH-1:0]   high;
    logic [DEFAULT_CNT_WIDTH-1:0]   low;
    logic [DEFAULT_CNT_WIDTH-1:0]   count;
  } cfg_t;

  // A zero-length phase still lasts one clock.
  function automatic logic [DEFAULT_CNT_WIDTH-1:0] at_least_one(input logic [DEFAULT_CNT_WIDTH-1:0] v);
    return (v == '0) ? DEFAULT_CNT_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/pulse_train_generator.sv
// Emits a burst of N pulses (or continuous until abort) with programmable high/low time on masked lines.
// Outputs registered, first rising edge one clock after start; start is ignored while busy.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int NUM_OUTPUTS = DEFAULT_NUM_OUTPUTS,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_OUTPUTS-1:0] channel_mask,
  input  logic [CNT_WIDTH-1:0]   high_cycles,
  input  logic [CNT_WIDTH-1:0]   low_cycles,
  input  logic [CNT_WIDTH-1:0]   pulse_count,
  output logic [NUM_OUTPUTS-1:0] output_signals,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   pulses_sent
);

  state_t               state;
  cfg_t                 cfg;
  logic [CNT_WIDTH-1:0] timer;
  logic                 last_pulse;

  // Count of zero means continuous; wrap of pulses_sent is then harmless.
  assign last_pulse = (cfg.count != '0) && (pulses_sent == CNT_WIDTH'(cfg.count));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= IDLE;
      cfg            <= '0;
      timer          <= '0;
      output_signals <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pulses_sent    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cfg.mask       <= DEFAULT_NUM_OUTPUTS'(channel_mask);
            cfg.high       <= DEFAULT_CNT_WIDTH'(high_cycles);
            cfg.low        <= DEFAULT_CNT_WIDTH'(low_cycles);
            cfg.count      <= DEFAULT_CNT_WIDTH'(pulse_count);
            timer          <= CNT_WIDTH'(at_least_one(DEFAULT_CNT_WIDTH'(high_cycles)));
            output_signals <= channel_mask;
            busy           <= 1'b1;
            done           <= 1'b0;
            pulses_sent    <= CNT_WIDTH'(1);
            state          <= HIGH;
          end
        end
        HIGH: begin
          if (abort) begin
            output_signals <= '0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else if (timer <= CNT_WIDTH'(1)) begin
            output_signals <= '0;
            if (last_pulse) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              timer <= CNT_WIDTH'(at_least_one(cfg.low));
              state <= LOW;
            end
          end else begin
            timer <= timer - CNT_WIDTH'(1);
          end
        end
        LOW: begin
          if (abort) begin
            output_signals <= '0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else if (timer <= CNT_WIDTH'(1)) begin
            output_signals <= NUM_OUTPUTS'(cfg.mask);
            pulses_sent    <= pulses_sent + CNT_WIDTH'(1);
            timer          <= CNT_WIDTH'(at_least_one(cfg.high));
            state          <= HIGH;
          end else begin
            timer <= timer - CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench: per-cycle expected waveform pushed to a queue at launch, popped against the DUT.
module tb_pulse_train_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  channel_mask = '0;
  logic [31:0] high_cycles = '0;
  logic [31:0] low_cycles = '0;
  logic [31:0] pulse_count = '0;
  logic [7:0]  output_signals;
  logic        busy;
  logic        done;
  logic [31:0] pulses_sent;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  out;
    logic        busy;
    logic [31:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_q[$];

  pulse_train_generator #(.NUM_OUTPUTS(8), .CNT_WIDTH(32)) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .start          (start),
    .abort          (abort),
    .channel_mask   (channel_mask),
    .high_cycles    (high_cycles),
    .low_cycles     (low_cycles),
    .pulse_count    (pulse_count),
    .output_signals (output_signals),
    .busy           (busy),
    .done           (done),
    .pulses_sent    (pulses_sent)
  );

  always #5 clk = ~clk;

  // Expected per-cycle waveform from the edge-time formulas, plus the idle cycle after the burst.
  task automatic push_burst(input logic [7:0] mask, input int h, input int l, input int n);
    int he, le, last;
    exp_t e;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    last = (n - 1) * (he + le) + he;
    for (int t = 1; t <= last; t++) begin
      e.out  = (((t - 1) % (he + le)) < he) ? mask : 8'h00;
      e.busy = 1'b1;
      e.ps   = 32'((t - 1) / (he + le) + 1);
      exp_q.push_back(e);
    end
    e.out = 8'h00; e.busy = 1'b0; e.ps = 32'(n);
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic [7:0] mask, input int h, input int l, input int n);
    channel_mask = mask;
    high_cycles  = 32'(h);
    low_cycles   = 32'(l);
    pulse_count  = 32'(n);
    start        = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (output_signals !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", output_signals); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pulses_sent !== 32'd0) begin errors++; $display("FAIL reset_ps: got %0d want 0", pulses_sent); end
  endtask

  task automatic test_basic(input string name);
    exp_t e;
    launch(8'h05, 2, 3, 4);
    push_burst(8'h05, 2, 3, 4);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (output_signals !== e.out || busy !== e.busy || pulses_sent !== e.ps) begin
        errors++; $display("FAIL %s_wave: got out=%h busy=%b ps=%0d want out=%h busy=%b ps=%0d",
                           name, output_signals, busy, pulses_sent, e.out, e.busy, e.ps);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, done); end
  endtask

  task automatic test_zero_phase();
    exp_t e;
    launch(8'hFF, 0, 0, 3);
    push_burst(8'hFF, 0, 0, 3);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (output_signals !== e.out || busy !== e.busy || pulses_sent !== e.ps) begin
        errors++; $display("FAIL zero_wave: got out=%h busy=%b ps=%0d want out=%h busy=%b ps=%0d",
                           output_signals, busy, pulses_sent, e.out, e.busy, e.ps);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
  endtask

  task automatic test_continuous_abort();
    logic [7:0] prev = 8'h00;
    int rises = 0;
    launch(8'hFF, 1, 1, 0);
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      if (output_signals[0] && !prev[0]) rises++;
      prev = output_signals;
      if (t == 9) abort = 1'b1;
    end
    checks++; if (output_signals !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: got out=%h busy=%b want out=00 busy=0", output_signals, busy);
    end
    checks++; if (rises !== 5) begin errors++; $display("FAIL abort_rises: got %0d want 5", rises); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (pulses_sent !== 32'd5) begin errors++; $display("FAIL abort_ps: got %0d want 5", pulses_sent); end
    repeat (3) @(posedge clk); #1;
    checks++; if (output_signals !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_hold: got out=%h busy=%b want out=00 busy=0", output_signals, busy);
    end
  endtask

  task automatic test_collisions();
    exp_t e;
    int i = 0;
    launch(8'h05, 2, 3, 4);
    push_burst(8'h05, 2, 3, 4);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; start = 1'b0;
      i++;
      if (i == 3) begin start = 1'b1; pulse_count = 32'd1; high_cycles = 32'd7; channel_mask = 8'hF0; end
      if (i == 8) start = 1'b1;
      e = exp_q.pop_front();
      checks++; if (output_signals !== e.out || busy !== e.busy || pulses_sent !== e.ps) begin
        errors++; $display("FAIL collide_wave: got out=%h busy=%b ps=%0d want out=%h busy=%b ps=%0d",
                           output_signals, busy, pulses_sent, e.out, e.busy, e.ps);
      end
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || output_signals !== 8'h00) begin
      errors++; $display("FAIL start_abort_idle: got busy=%b out=%h want busy=0 out=00", busy, output_signals);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle2: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    launch(8'h81, 1, 2, 2);
    push_burst(8'h81, 1, 2, 2);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (output_signals !== e.out || busy !== e.busy || pulses_sent !== e.ps) begin
        errors++; $display("FAIL b2b_wave: got out=%h busy=%b ps=%0d want out=%h busy=%b ps=%0d",
                           output_signals, busy, pulses_sent, e.out, e.busy, e.ps);
      end
    end
    launch(8'h3C, 1, 1, 1);
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1 || output_signals !== 8'h3C || done !== 1'b0 || pulses_sent !== 32'd1) begin
      errors++; $display("FAIL b2b_restart: got busy=%b out=%h done=%b ps=%0d want busy=1 out=3c done=0 ps=1",
                         busy, output_signals, done, pulses_sent);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    launch(8'hFF, 5, 5, 3);
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (output_signals !== 8'h00 || busy !== 1'b0 || pulses_sent !== 32'd0) begin
      errors++; $display("FAIL async_reset: got out=%h busy=%b ps=%0d want out=00 busy=0 ps=0",
                         output_signals, busy, pulses_sent);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    test_basic("post_reset");
  endtask

  task automatic test_loopback(input int n);
    logic [7:0] prev = 8'h00;
    int cnt[8];
    int want;
    bit finished = 1'b0;
    foreach (cnt[j]) cnt[j] = 0;
    launch(8'hFF, 5, 5, n);
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(posedge clk); #1; start = 1'b0;
      for (int j = 0; j < 8; j++) if (output_signals[j] && !prev[j]) cnt[j]++;
      prev = output_signals;
      if (!busy) finished = 1'b1;
    end
    checks++; if (!finished) begin errors++; $display("FAIL loopback_timeout: got busy=%b want 0", busy); end
    want = cnt_q.pop_front();
    for (int j = 0; j < 8; j++) begin
      checks++; if (cnt[j] !== want) begin errors++; $display("FAIL loopback_line%0d: got %0d want %0d", j, cnt[j], want); end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic("basic");
    test_zero_phase();
    test_continuous_abort();
    test_collisions();
    test_back_to_back();
    test_async_reset();
    cnt_q.push_back(1000);
    test_loopback(1000);
    cnt_q.push_back(24);
    test_loopback(24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
